// File: rtl/rx_fifo.sv
// Receive byte FIFO behind the UART receiver: edge-detects rxDone, queues rxData, show-ahead read side.
// Optional RX_FIFO_OVERWRITE_EN: a push into a full FIFO replaces the oldest entry instead of being dropped.
module rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 8
) (
  input  logic                  baudClk,
  input  logic                  resetN,
  input  logic [DATA_W-1:0]     rxData,
  input  logic                  rxDone,
  input  logic                  rdEn,
  input  logic                  clrOvf,
  output logic [DATA_W-1:0]     rdData,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow
);

  localparam int                    DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_DEPTH = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  rx_done_prev_q;
  logic                  push, pop_req, mem_we, is_full, is_empty;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_DEPTH);
  assign push     = rxDone & ~rx_done_prev_q;
  assign pop_req  = rdEn & ~is_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = clrOvf ? 1'b0 : ovf_q;
    mem_we   = 1'b0;
    if (push && !is_full) begin
      mem_we   = 1'b1;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_req) rd_ptr_d = rd_ptr_q + PTR_ONE;
      else         count_d  = count_q + CNT_ONE;
    end else if (push) begin
      if (pop_req) begin
        // Full with a simultaneous pop: room is made in the same cycle, so no overflow.
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        ovf_d = 1'b1;
`ifdef RX_FIFO_OVERWRITE_EN
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        rd_ptr_d = rd_ptr_q + PTR_ONE;
`endif
      end
    end else if (pop_req) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      count_d  = count_q - CNT_ONE;
    end
  end

  // rx_done_prev_q resets high so a level already asserted at reset release is not a push.
  always_ff @(posedge baudClk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      ovf_q          <= 1'b0;
      rx_done_prev_q <= 1'b1;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      ovf_q          <= ovf_d;
      rx_done_prev_q <= rxDone;
    end
  end

  always_ff @(posedge baudClk) begin
    if (mem_we) mem_q[wr_ptr_q] <= rxData;
  end

  assign rdData   = mem_q[rd_ptr_q];
  assign empty    = is_empty;
  assign full     = is_full;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_rx_fifo.sv
// Directed bench for rx_fifo: reset behaviour, ordering, full/overflow handling, empty pops, async reset.
module tb_rx_fifo;

  logic       baudClk;
  logic       resetN;
  logic [7:0] rxData;
  logic       rxDone;
  logic       rdEn;
  logic       clrOvf;
  logic [7:0] rdData;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;

  int n_checks = 0;
  int n_errors = 0;

  rx_fifo #(.DEPTH_LOG2(4), .DATA_W(8)) dut (
    .baudClk (baudClk),
    .resetN  (resetN),
    .rxData  (rxData),
    .rxDone  (rxDone),
    .rdEn    (rdEn),
    .clrOvf  (clrOvf),
    .rdData  (rdData),
    .empty   (empty),
    .full    (full),
    .count   (count),
    .overflow(overflow)
  );

  initial baudClk = 1'b0;
  always #5 baudClk = ~baudClk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Inputs change on the falling edge, results are observed on the following falling edge.
  task automatic push_byte(input logic [7:0] b, input int hold);
    rxData = b;
    rxDone = 1'b1;
    repeat (hold) @(negedge baudClk);
    rxDone = 1'b0;
    @(negedge baudClk);
  endtask

  task automatic pop_one();
    rdEn = 1'b1;
    @(negedge baudClk);
    rdEn = 1'b0;
  endtask

  logic [7:0] exp_b;

  initial begin
    resetN = 1'b0;
    rxData = 8'h00;
    rxDone = 1'b1;
    rdEn   = 1'b0;
    clrOvf = 1'b0;
    repeat (2) @(negedge baudClk);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);

    // rxDone high across reset release must not push
    resetN = 1'b1;
    repeat (5) @(negedge baudClk);
    chk("hold_empty", empty, 1);
    chk("hold_count", count, 0);
    rxDone = 1'b0;
    @(negedge baudClk);

    push_byte(8'hA5, 10);
    push_byte(8'h3C, 1);
    chk("two_count", count, 2);
    chk("two_head", rdData, 8'hA5);
    pop_one();
    chk("pop1_data", rdData, 8'h3C);
    chk("pop1_count", count, 1);
    pop_one();
    chk("pop2_empty", empty, 1);

    for (int i = 0; i < 16; i++) push_byte(8'(i), 1);
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    chk("fill_ovf", overflow, 0);
    push_byte(8'h55, 1);
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 16);
`ifdef RX_FIFO_OVERWRITE_EN
    chk("ovf_head", rdData, 8'h01);
`else
    chk("ovf_head", rdData, 8'h00);
`endif
    for (int i = 0; i < 16; i++) begin
`ifdef RX_FIFO_OVERWRITE_EN
      exp_b = (i < 15) ? 8'(i + 1) : 8'h55;
`else
      exp_b = 8'(i);
`endif
      chk($sformatf("drain0_%0d", i), rdData, exp_b);
      pop_one();
    end
    chk("drain0_empty", empty, 1);
    chk("ovf_sticky", overflow, 1);
    clrOvf = 1'b1;
    @(negedge baudClk);
    clrOvf = 1'b0;
    chk("ovf_clr", overflow, 0);

    // Full FIFO with push and pop in the same cycle
    for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i), 1);
    chk("fill2_full", full, 1);
    rxData = 8'h77;
    rxDone = 1'b1;
    rdEn   = 1'b1;
    @(negedge baudClk);
    rxDone = 1'b0;
    rdEn   = 1'b0;
    chk("pp_count", count, 16);
    chk("pp_ovf", overflow, 0);
    chk("pp_head", rdData, 8'h21);
    @(negedge baudClk);

    // Overflow event and clear in the same cycle: set wins
    rxData = 8'h66;
    rxDone = 1'b1;
    clrOvf = 1'b1;
    @(negedge baudClk);
    rxDone = 1'b0;
    clrOvf = 1'b0;
    chk("setwins_ovf", overflow, 1);
    chk("setwins_count", count, 16);
    @(negedge baudClk);
    clrOvf = 1'b1;
    @(negedge baudClk);
    clrOvf = 1'b0;
    chk("clr2_ovf", overflow, 0);
    for (int i = 0; i < 16; i++) begin
`ifdef RX_FIFO_OVERWRITE_EN
      exp_b = (i < 14) ? 8'h22 + 8'(i) : ((i == 14) ? 8'h77 : 8'h66);
`else
      exp_b = (i < 15) ? 8'h21 + 8'(i) : 8'h77;
`endif
      chk($sformatf("drain1_%0d", i), rdData, exp_b);
      pop_one();
    end
    chk("drain1_empty", empty, 1);
    chk("drain1_count", count, 0);

    // Pops while empty are ignored
    rdEn = 1'b1;
    repeat (4) @(negedge baudClk);
    chk("emptypop_count", count, 0);
    chk("emptypop_empty", empty, 1);
    rxData = 8'h12;
    rxDone = 1'b1;
    @(negedge baudClk);
    rxDone = 1'b0;
    chk("pe_count", count, 1);
    chk("pe_data", rdData, 8'h12);
    @(negedge baudClk);
    rdEn = 1'b0;
    chk("pe_drained", empty, 1);

    // Build count=5 with overflow set, then assert reset between clock edges
    for (int i = 0; i < 16; i++) push_byte(8'h40 + 8'(i), 1);
    push_byte(8'h99, 1);
    for (int i = 0; i < 11; i++) pop_one();
    chk("pre_rst_count", count, 5);
    chk("pre_rst_ovf", overflow, 1);
    #2 resetN = 1'b0;
    #1;
    chk("async_count", count, 0);
    chk("async_empty", empty, 1);
    chk("async_ovf", overflow, 0);
    chk("async_full", full, 0);
    @(negedge baudClk);
    resetN = 1'b1;
    @(negedge baudClk);
    chk("post_rst_empty", empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
